bus_mem_ctrl: RTL
=================

Name: bus_mem_ctrl

Overview:
- Bus slave directly downstream of the 4-bit CPU core: owns the CPU's 12-bit nibble address space and answers its bus_addr / bus_data_rw / bus_data_out / bus_data_in interface.
- Provides a small on-chip nibble RAM, a memory-mapped I/O window (GPIO out, GPIO in, status), and a program loader.
- While loading, the loader holds the CPU in reset and streams nibbles into RAM over a valid/ready handshake.

Parameters:
- ADDR_W, 8, RAM address width; RAM depth = 2^ADDR_W nibbles.
- IO_BASE, 12'hFF0, base of the 16-nibble I/O window; IO_BASE[3:0] must be 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- bus_addr  in  12  CPU address.
- bus_data_rw  in  1  1 = write, 0 = read.
- bus_data_out  in  4  CPU write data.
- bus_data_in  out  4  read data to CPU.
- load_en  in  1  level; request program-load mode.
- load_valid  in  1  loader nibble valid.
- load_data  in  4  loader nibble.
- load_ready  out  1  loader may transfer.
- cpu_rst_n  out  1  active-low reset driven to the CPU.
- gpio_in  in  4  asynchronous external inputs.
- gpio_out  out  4  GPIO output register.

Behaviour:
- Reset (rst_n=0 at a posedge): FSM=LOAD_IDLE, load pointer=0, gpio_out=0, both sync flops=0, status=0, load_ready=0, cpu_rst_n=0. RAM contents are not reset.
- FSM states:
  - LOAD_IDLE: cpu_rst_n=0. Go to LOADING if load_en=1, else to RUN.
  - LOADING: cpu_rst_n=0, load_ready=1. Each cycle with load_valid&load_ready writes load_data to RAM[ptr], then ptr increments mod 2^ADDR_W. Wrap past the top sets status[1] (overflow, sticky until reset or next entry to LOADING). load_en=0 goes to RUN; a transfer in that same cycle still completes.
  - RUN: cpu_rst_n=1, load_ready=0. load_en=1 goes to LOADING, clears ptr and status[1], and drives cpu_rst_n=0 from the next cycle.
- cpu_rst_n and load_ready are registered from the FSM state. cpu_rst_n rises exactly one cycle after entry to RUN.
- Address decode: addr[11:4]==IO_BASE[11:4] selects I/O. Otherwise RAM index = addr[ADDR_W-1:0]; upper bits are ignored, so addresses alias.
- Read path: bus_data_in is combinational from bus_addr (asynchronous RAM read / I/O mux). The CPU drives an address at edge N and samples at edge N+1, so there is zero added latency.
- I/O map:
  - +0 gpio_out, R/W.
  - +1 synced gpio_in, RO.
  - +2 status, RO: [0]=1 in RUN, [1]=load overflow, [3:2]=0.
  - +3 scratch nibble, R/W, reset 0.
  - +4..+F read 0; writes ignored.
- Write path: at every posedge in RUN with bus_data_rw=1, bus_data_out is written to the decoded target.
  - The CPU asserts rw with the address one cycle before its data is valid, so the first edge may write stale data; the second edge overwrites it. Last write wins, and this is required behaviour.
  - Writes to RO or unmapped I/O are ignored.
- Bus writes are ignored outside RUN. Bus reads in LOADING still return RAM data.
- gpio_in passes through a 2-flop synchroniser; a read reflects a pin change 2 cycles later.
- Simultaneous load transfer and entry to RUN: the transfer commits, and ptr increments once.
- Reset mid-load: FSM returns to LOAD_IDLE, ptr=0, and RAM already written is kept.

Test Plan:
- Reset, load_en=1, stream nibbles 3,2,1 with load_valid held: RAM[0..2]=3,2,1, ptr=3, cpu_rst_n=0. Drop load_en: cpu_rst_n=1 one cycle after RUN, status reads 4'b0001.
- Stream 2^ADDR_W+1 nibbles: RAM[0] holds the last nibble, status[1]=1. Re-entering LOADING clears status[1].
- RUN, bus_addr=12'h012 then 12'h112 (alias): both return RAM[0x12] in the same cycle as the address change.
- STO-style write: rw=1 with addr=0xFF0 and data_out=9 for one cycle, then data_out=5 for one cycle, then rw=0. Result: gpio_out=5 and a read of 0xFF0 returns 5.
- gpio_in steps 0 to A: read of 0xFF1 returns 0 for two edges, then A. Write to 0xFF1 with rw=1: no change.
- rst_n pulsed low during LOADING after 2 transfers: ptr=0, gpio_out=0, cpu_rst_n=0, and RAM[0..1] are kept.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
// bus_mem_ctrl : CPU bus slave with nibble RAM, I/O window and program loader
// Revision 1.0 : initial release
// ============================================================================
module bus_mem_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter logic [11:0] IO_BASE = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_data_out,
  output logic [3:0]  bus_data_in,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [3:0]  load_data,
  output logic        load_ready,
  output logic        cpu_rst_n,
  input  logic [3:0]  gpio_in,
  output logic [3:0]  gpio_out
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOADING   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              load_ready_q, cpu_rst_n_q;
  logic [3:0]        gpio_q, gpio_d;
  logic [3:0]        scratch_q, scratch_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        mem [DEPTH];

  logic              load_xfer;
  logic              bus_wr;
  logic              io_sel;
  logic [3:0]        io_off;
  logic              enter_load;
  logic [3:0]        status;
  logic [3:0]        rd_data;

  assign load_xfer  = load_valid & load_ready_q;
  assign bus_wr     = (state_q == RUN) & bus_data_rw;
  assign io_sel     = (bus_addr[11:4] == IO_BASE[11:4]);
  assign io_off     = bus_addr[3:0];
  assign enter_load = (state_d == LOADING) && (state_q != LOADING);
  assign status     = {2'b00, ovf_q, (state_q == RUN)};

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_IDLE: state_d = load_en ? LOADING : RUN;
      LOADING:   state_d = load_en ? LOADING : RUN;
      RUN:       state_d = load_en ? LOADING : RUN;
      default:   state_d = LOAD_IDLE;
    endcase
  end

  // A fresh load session restarts at RAM[0] with a clean overflow flag.
  always_comb begin
    ptr_d     = ptr_q;
    ovf_d     = ovf_q;
    gpio_d    = gpio_q;
    scratch_d = scratch_q;
    if (enter_load) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end else if (load_xfer) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
    end
    if (bus_wr && io_sel) begin
      if (io_off == 4'h0) gpio_d    = bus_data_out;
      if (io_off == 4'h3) scratch_d = bus_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD_IDLE;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      load_ready_q <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      gpio_q       <= 4'h0;
      scratch_q    <= 4'h0;
      sync1_q      <= 4'h0;
      sync2_q      <= 4'h0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      load_ready_q <= (state_d == LOADING);
      cpu_rst_n_q  <= (state_q == RUN);
      gpio_q       <= gpio_d;
      scratch_q    <= scratch_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
    end
  end

  // RAM has no reset; writes are suppressed while rst_n is low so a reset
  // mid-load cannot commit a stray nibble.
  always_ff @(posedge clk) begin
    if (rst_n && load_xfer) begin
      mem[ptr_q] <= load_data;
    end else if (rst_n && bus_wr && !io_sel) begin
      mem[bus_addr[ADDR_W-1:0]] <= bus_data_out;
    end
  end

  always_comb begin
    rd_data = mem[bus_addr[ADDR_W-1:0]];
    if (io_sel) begin
      case (io_off)
        4'h0:    rd_data = gpio_q;
        4'h1:    rd_data = sync2_q;
        4'h2:    rd_data = status;
        4'h3:    rd_data = scratch_q;
        default: rd_data = 4'h0;
      endcase
    end
  end

  assign bus_data_in = rd_data;
  assign load_ready  = load_ready_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign gpio_out    = gpio_q;

endmodule
`default_nettype wire
